// File: rtl/module_pipelined_cla_adder.sv
// Pipelined carry look-ahead adder/subtractor: one BLOCK_WIDTH slice is resolved
// per stage, the slice carry is registered and handed to the next stage.
module module_pipelined_cla_adder #(
  parameter int CLA_WIDTH   = 32,
  parameter int BLOCK_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [CLA_WIDTH-1:0] a_i,
  input  logic [CLA_WIDTH-1:0] b_i,
  input  logic                 carry_i,
  input  logic                 sub_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CLA_WIDTH-1:0] sum_o,
  output logic                 carry_o,
  output logic                 overflow_o
);

  localparam int BW_SAFE    = (BLOCK_WIDTH >= 1) ? BLOCK_WIDTH : 1;
  localparam int NUM_STAGES = CLA_WIDTH / BW_SAFE;
  localparam int NUM_GROUPS = (BW_SAFE + 3) / 4;
  localparam int LAST       = NUM_STAGES - 1;

  if (BLOCK_WIDTH < 1 || (CLA_WIDTH % BW_SAFE) != 0) begin : g_bad_cfg
    $error("BLOCK_WIDTH must be >= 1 and divide CLA_WIDTH");
  end

  // Slice adder: 4-bit groups produce generate/propagate, group carries are
  // looked ahead across the slice, bit carries are then resolved inside each group.
  function automatic logic [BW_SAFE:0] cla_slice(input logic [BW_SAFE-1:0] a,
                                                 input logic [BW_SAFE-1:0] b,
                                                 input logic               cin);
    logic [BW_SAFE-1:0]  p;
    logic [BW_SAFE-1:0]  g;
    logic [BW_SAFE:0]    c;
    logic [NUM_GROUPS:0] gc;
    logic                grp_g;
    logic                grp_p;
    p     = a ^ b;
    g     = a & b;
    gc    = '0;
    gc[0] = cin;
    for (int j = 0; j < NUM_GROUPS; j++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (j * 4 + i < BW_SAFE) begin
          grp_g = g[j*4+i] | (p[j*4+i] & grp_g);
          grp_p = grp_p & p[j*4+i];
        end
      end
      gc[j+1] = grp_g | (grp_p & gc[j]);
    end
    c = '0;
    for (int k = 0; k < BW_SAFE; k++) begin
      if (k % 4 == 0) c[k] = gc[k/4];
      c[k+1] = g[k] | (p[k] & c[k]);
    end
    c[BW_SAFE] = gc[NUM_GROUPS];
    return {c[BW_SAFE], p ^ c[BW_SAFE-1:0]};
  endfunction

  function automatic logic [CLA_WIDTH-1:0] merge_slice(input logic [CLA_WIDTH-1:0] base,
                                                       input logic [BW_SAFE-1:0]   slice,
                                                       input int                   idx);
    logic [CLA_WIDTH-1:0] r;
    r = base;
    r[idx*BW_SAFE +: BW_SAFE] = slice;
    return r;
  endfunction

  logic                  adv;
  logic                  accept;
  logic [CLA_WIDTH-1:0]  b_eff;
  logic                  c_eff;

  logic [NUM_STAGES-1:0] vld_q;
  logic [NUM_STAGES-1:0] vld_d;
  logic [NUM_STAGES-1:0] vld_in;
  logic [NUM_STAGES-1:0] ld;
  logic [NUM_STAGES-1:0] cin;
  logic [NUM_STAGES-1:0] cy_d;
  logic [NUM_STAGES-1:0] cy_q;
  logic [CLA_WIDTH-1:0]  a_d     [NUM_STAGES];
  logic [CLA_WIDTH-1:0]  b_d     [NUM_STAGES];
  logic [CLA_WIDTH-1:0]  sum_in  [NUM_STAGES];
  logic [CLA_WIDTH-1:0]  sum_d   [NUM_STAGES];
  logic [CLA_WIDTH-1:0]  a_q     [NUM_STAGES];
  logic [CLA_WIDTH-1:0]  b_q     [NUM_STAGES];
  logic [CLA_WIDTH-1:0]  sum_q   [NUM_STAGES];
  logic                  ovf_d;
  logic                  ovf_q;

  // The whole pipe moves together; a full output that is not taken freezes it.
  assign adv     = !vld_q[LAST] || ready_i;
  assign ready_o = adv && !rst_i;
  assign accept  = valid_i && ready_o;
  assign b_eff   = sub_i ? ~b_i : b_i;
  assign c_eff   = carry_i ^ sub_i;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [BW_SAFE:0] res;

    if (k == 0) begin : g_head
      assign a_d[k]    = a_i;
      assign b_d[k]    = b_eff;
      assign cin[k]    = c_eff;
      assign sum_in[k] = '0;
      assign vld_in[k] = accept;
    end else begin : g_tail
      assign a_d[k]    = a_q[k-1];
      assign b_d[k]    = b_q[k-1];
      assign cin[k]    = cy_q[k-1];
      assign sum_in[k] = sum_q[k-1];
      assign vld_in[k] = vld_q[k-1];
    end

    assign res      = cla_slice(a_d[k][k*BW_SAFE +: BW_SAFE], b_d[k][k*BW_SAFE +: BW_SAFE], cin[k]);
    assign cy_d[k]  = res[BW_SAFE];
    assign sum_d[k] = merge_slice(sum_in[k], res[BW_SAFE-1:0], k);
    assign vld_d[k] = adv ? vld_in[k] : vld_q[k];
    // Data registers only load real operations, so bubbles never disturb held values.
    assign ld[k]    = adv && vld_in[k];
  end

  assign ovf_d = (a_d[LAST][CLA_WIDTH-1] == b_d[LAST][CLA_WIDTH-1]) &&
                 (sum_d[LAST][CLA_WIDTH-1] != a_d[LAST][CLA_WIDTH-1]);

  // ---- stage registers; the last stage doubles as the output register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q       <= '0;
      sum_q[LAST] <= '0;
      cy_q[LAST]  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (ld[k]) begin
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          sum_q[k] <= sum_d[k];
          cy_q[k]  <= cy_d[k];
        end
      end
      if (ld[LAST]) ovf_q <= ovf_d;
    end
  end

  assign valid_o    = vld_q[LAST];
  assign sum_o      = sum_q[LAST];
  assign carry_o    = cy_q[LAST];
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_module_pipelined_cla_adder.sv
// Self-checking bench for module_pipelined_cla_adder (16-bit, 4-bit slices, 4 stages):
// directed corner vectors, throughput, backpressure, reset flush and random regression.
module tb_module_pipelined_cla_adder;

  localparam int W  = 16;
  localparam int BW = 4;
  localparam int NS = W / BW;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         carry_i;
  logic         sub_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic         carry_o;
  logic         overflow_o;

  module_pipelined_cla_adder #(.CLA_WIDTH(W), .BLOCK_WIDTH(BW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .carry_i    (carry_i),
    .sub_i      (sub_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .sum_o      (sum_o),
    .carry_o    (carry_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {overflow, carry, sum}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic s);
    int   ua, ub, sa, sb, u, sr;
    logic cy, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      u  = ua + ub + int'(c);
      sr = sa + sb + int'(c);
      cy = (u > 65535);
    end else begin
      u  = ua - ub - int'(c);
      sr = sa - sb - int'(c);
      cy = (u >= 0);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, cy, u[15:0]};
  endfunction

  int          edge_cnt = 0;
  logic [17:0] exp_q[$];
  logic [17:0] rx_log[$];
  int          rx_edge[$];
  int          tx_edge[$];
  logic        last_acc = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Handshakes seen at the falling edge take effect at the following rising edge.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      last_acc <= 1'b0;
    end else begin
      if (valid_o && ready_i) begin
        check("out_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check("result", 32'({overflow_o, carry_o, sum_o}), 32'(exp_q.pop_front()));
        rx_log.push_back({overflow_o, carry_o, sum_o});
        rx_edge.push_back(edge_cnt + 1);
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(model(a_i, b_i, carry_i, sub_i));
        tx_edge.push_back(edge_cnt + 1);
      end
      last_acc <= valid_i && ready_o;
    end
  end

  task automatic put_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    int guard = 0;
    valid_i = 1'b1;
    a_i     = a;
    b_i     = b;
    carry_i = c;
    sub_i   = s;
    @(negedge clk);
    while (!ready_o && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!ready_o) check("accept_timeout", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    valid_i = 1'b0;
    @(negedge clk);
    while ((exp_q.size() != 0 || valid_o) && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic dir_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic [17:0] exp);
    int base = rx_log.size();
    int tb0  = tx_edge.size();
    put_op(a, b, c, s);
    drain();
    if (rx_log.size() > base) begin
      check(tag, 32'(rx_log[base]), 32'(exp));
      check({tag, "_lat"}, rx_edge[base] - tx_edge[tb0], NS);
    end else begin
      check({tag, "_missing"}, rx_log.size(), base + 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, tb0, guard, acc0;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    a_i     = '0;
    b_i     = '0;
    carry_i = 1'b0;
    sub_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_sum_o", 32'(sum_o), 32'd0);
    check("rst_carry_o", 32'(carry_o), 32'd0);
    check("rst_ovf_o", 32'(overflow_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;

    // Directed corners
    dir_op("add_cross_slice", 16'h00FF, 16'h0001, 1'b0, 1'b0, 18'h00100);
    dir_op("add_wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
    dir_op("add_ovf",         16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    dir_op("sub_ovf",         16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);
    dir_op("sub_neg",         16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
    dir_op("add_all_ones_ci", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1 ^ 1'b1, 18'h1FFFF);
    dir_op("sub_borrow_in",   16'h0010, 16'h0005, 1'b1, 1'b1, 18'h1000A);

    // Operand changes without valid_i must not produce anything
    base = rx_log.size();
    for (int i = 0; i < 5; i++) begin
      a_i     = W'($urandom);
      b_i     = W'($urandom);
      sub_i   = 1'($urandom);
      carry_i = 1'($urandom);
      @(negedge clk);
      check("idle_no_output", rx_log.size(), base);
      check("idle_hold", 32'({overflow_o, carry_o, sum_o}), 32'(18'h1000A));
      @(posedge clk);
      #1;
    end

    // Throughput: 8 back-to-back ops
    base = rx_log.size();
    tb0  = tx_edge.size();
    for (int i = 0; i < 8; i++)
      put_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    drain();
    check("tput_count", rx_log.size() - base, 8);
    if (rx_log.size() >= base + 8) begin
      check("tput_latency", rx_edge[base] - tx_edge[tb0], NS);
      for (int i = 1; i < 8; i++)
        check("tput_gap", rx_edge[base+i] - rx_edge[base+i-1], 1);
    end

    // Backpressure: 6 ops, ready_i low for 3 cycles after the first result
    base = rx_log.size();
    fork
      begin
        for (int i = 0; i < 6; i++)
          put_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        valid_i = 1'b0;
      end
      begin
        int g = 0;
        @(negedge clk);
        while (!valid_o && g < 50) begin
          g++;
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          check("bp_ready_o", 32'(ready_o), 32'd0);
          check("bp_valid_o", 32'(valid_o), 32'd1);
          if (exp_q.size() != 0)
            check("bp_hold", 32'({overflow_o, carry_o, sum_o}), 32'(exp_q[0]));
          @(posedge clk);
          #1;
          if (i == 2) ready_i = 1'b1;
          else @(negedge clk);
        end
      end
    join
    drain();
    check("bp_delivered", rx_log.size() - base, 6);

    // Reset with three operations in flight
    base = rx_log.size();
    for (int i = 0; i < 3; i++)
      put_op(W'($urandom | 32'h1), W'($urandom), 1'($urandom), 1'b0);
    valid_i = 1'b0;
    rst_i   = 1'b1;
    @(negedge clk);
    check("rst_mid_ready_o", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_mid_valid_o", 32'(valid_o), 32'd0);
    check("rst_mid_sum_o", 32'({overflow_o, carry_o, sum_o}), 32'd0);
    repeat (6) @(negedge clk);
    check("rst_mid_discard", rx_log.size(), base);
    @(posedge clk);
    #1;
    dir_op("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555);

    // Random regression with random downstream readiness
    base  = rx_log.size();
    acc0  = tx_edge.size();
    guard = 0;
    while ((tx_edge.size() - acc0) < 1000 && guard < 20000) begin
      guard++;
      ready_i = 1'($urandom_range(0, 1));
      if (!valid_i || last_acc) begin
        valid_i = ($urandom_range(0, 3) != 0);
        a_i     = W'($urandom);
        b_i     = W'($urandom);
        carry_i = 1'($urandom);
        sub_i   = 1'($urandom);
      end
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    check("rand_accepted", tx_edge.size() - acc0, 1000);
    drain();
    check("rand_delivered", rx_log.size() - base, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
